// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU datapath, host loader), the arbiter and the memory model.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_lock;
  logic          cpu_gnt;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_lock;
  logic          host_gnt;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_ack, cpu_rdata,
    output host_gnt, host_ack, host_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_ack, cpu_rdata,
    input  host_gnt, host_ack, host_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/host arbiter for the unified memory, one transaction in flight, fixed latency.
// Optional burst lock enabled by defining ARB_LOCK_EN.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          i_clock,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  // state  | meaning
  // IDLE   | no owner, arbitrate pending requests
  // ACCESS | memory strobes driven for MEM_LAT cycles
  // RESP   | owner's ack pulse, memory idle
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner_host;
  logic          r_last_host;
  logic          r_cpu_gnt, r_host_gnt;
  logic          r_cpu_ack, r_host_ack;
  logic [DW-1:0] r_cpu_rdata, r_host_rdata;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we, r_mem_re;

  logic w_any_req;
  logic w_pick_cpu;
  logic w_lock_cpu, w_lock_host;

`ifdef ARB_LOCK_EN
  logic r_lock_valid;
  logic r_lock_host;
  assign w_lock_cpu  = r_lock_valid && !r_lock_host && bus.cpu_req;
  assign w_lock_host = r_lock_valid &&  r_lock_host && bus.host_req;
`else
  assign w_lock_cpu  = 1'b0;
  assign w_lock_host = 1'b0;
`endif

  assign w_any_req  = bus.cpu_req || bus.host_req;
  // A live lock overrides the tie-break; otherwise the last owner yields.
  assign w_pick_cpu = bus.cpu_req &&
                      (!bus.host_req || w_lock_cpu || (!w_lock_host && r_last_host));

  always_ff @(posedge i_clock or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_owner_host <= 1'b0;
      r_last_host  <= 1'b1;
      r_cpu_gnt    <= 1'b0;
      r_host_gnt   <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
`ifdef ARB_LOCK_EN
      r_lock_valid <= 1'b0;
      r_lock_host  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
`ifdef ARB_LOCK_EN
          r_lock_valid <= 1'b0;
`endif
          if (w_any_req) begin
            r_owner_host <= !w_pick_cpu;
            r_last_host  <= !w_pick_cpu;
            r_cpu_gnt    <= w_pick_cpu;
            r_host_gnt   <= !w_pick_cpu;
            r_cnt        <= '0;
            r_mem_addr   <= w_pick_cpu ? bus.cpu_addr  : bus.host_addr;
            r_mem_wdata  <= w_pick_cpu ? bus.cpu_wdata : bus.host_wdata;
            r_mem_we     <= w_pick_cpu ? bus.cpu_we    : bus.host_we;
            r_mem_re     <= w_pick_cpu ? !bus.cpu_we   : !bus.host_we;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            if (!r_mem_we) begin
              if (r_owner_host) r_host_rdata <= bus.mem_rdata;
              else              r_cpu_rdata  <= bus.mem_rdata;
            end
            r_cpu_ack   <= !r_owner_host;
            r_host_ack  <= r_owner_host;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          r_cpu_ack  <= 1'b0;
          r_host_ack <= 1'b0;
          r_cpu_gnt  <= 1'b0;
          r_host_gnt <= 1'b0;
`ifdef ARB_LOCK_EN
          r_lock_valid <= r_owner_host ? bus.host_lock : bus.cpu_lock;
          r_lock_host  <= r_owner_host;
`endif
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_gnt    = r_cpu_gnt;
  assign bus.host_gnt   = r_host_gnt;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.host_ack   = r_host_ack;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.host_rdata = r_host_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_re     = r_mem_re;

endmodule
